// File: rtl/osc_ctrl_pkg.sv
// Shared definitions for the crystal oscillator start-up controller:
// FSM state encoding and PMU status bit positions.
package osc_ctrl_pkg;

  localparam int unsigned OSC_STATE_W = 3;

  typedef enum logic [OSC_STATE_W-1:0] {
    OSC_OFF     = 3'd0,
    OSC_STARTUP = 3'd1,
    OSC_MEASURE = 3'd2,
    OSC_READY   = 3'd3,
    OSC_FAIL    = 3'd4
  } osc_state_e;

  // Bit positions of the oscillator flags in the PMU status register
  localparam int unsigned STAT_EN_BIT    = 0;
  localparam int unsigned STAT_READY_BIT = 1;
  localparam int unsigned STAT_FAIL_BIT  = 2;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous pad oscillator into the reference clock domain
// and produces a one-cycle pulse per oscillator rising edge.
module osc_edge_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic osc_clk_in,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Two synchronizer stages followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/osc_startup_ctrl.sv
// Oscillator start-up sequencer and frequency monitor: enables the pad,
// waits the start-up time, then qualifies the oscillator by counting its
// edges over reference-clock windows, before and after declaring ready.
module osc_startup_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 4096,
  parameter int unsigned WIN_CYC     = 256,
  parameter int unsigned MIN_EDGES   = 6,
  parameter int unsigned MAX_EDGES   = 10,
  parameter int unsigned GOOD_WINS   = 2,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TMR_W       = 16,
  parameter int unsigned EW          = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   osc_req,
  input  logic                   osc_clk_in,
  output logic                   osc_en,
  output logic                   osc_ready,
  output logic                   osc_fail,
  output logic [EW-1:0]          edge_cnt_last,
  output logic [OSC_STATE_W-1:0] osc_state
);

  localparam int unsigned GW_W = $clog2(GOOD_WINS + 1);
  localparam int unsigned RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] START_TC   = TMR_W'(STARTUP_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_TC     = TMR_W'(WIN_CYC - 1);
  localparam logic [EW-1:0]    MIN_C      = EW'(MIN_EDGES);
  localparam logic [EW-1:0]    MAX_C      = EW'(MAX_EDGES);
  localparam logic [EW-1:0]    EDGE_SAT   = '1;
  localparam logic [GW_W-1:0]  GOOD_LAST  = GW_W'(GOOD_WINS - 1);
  localparam logic [RT_W-1:0]  RETRY_LAST = RT_W'(MAX_RETRY - 1);

  osc_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [GW_W-1:0]  good_q, good_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [EW-1:0]    last_d;

  logic          edge_pulse;
  logic [EW-1:0] eval_cnt;
  logic          win_end;
  logic          win_good;

  osc_edge_sync u_edge_sync (
    .clk        (clk),
    .rst_b      (rst_b),
    .osc_clk_in (osc_clk_in),
    .edge_pulse (edge_pulse)
  );

  // The window verdict already includes an edge arriving on the final cycle
  assign eval_cnt = (edge_pulse && (edge_cnt_q != EDGE_SAT)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  assign win_end  = (timer_q == WIN_TC);
  assign win_good = (eval_cnt >= MIN_C) && (eval_cnt <= MAX_C);

  // Next-state and counter update; a dropped request overrides everything
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    good_d     = good_q;
    retry_d    = retry_q;
    last_d     = edge_cnt_last;
    if (!osc_req) begin
      state_d    = OSC_OFF;
      timer_d    = '0;
      edge_cnt_d = '0;
      good_d     = '0;
      retry_d    = '0;
    end else begin
      unique case (state_q)
        OSC_OFF: state_d = OSC_STARTUP;
        OSC_STARTUP: begin
          if (timer_q == START_TC) begin
            state_d    = OSC_MEASURE;
            timer_d    = '0;
            edge_cnt_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        OSC_MEASURE, OSC_READY: begin
          if (win_end) begin
            timer_d    = '0;
            edge_cnt_d = '0;
            last_d     = eval_cnt;
            if (state_q == OSC_MEASURE) begin
              if (win_good) begin
                good_d = good_q + 1'b1;
                if (good_q == GOOD_LAST) state_d = OSC_READY;
              end else begin
                good_d  = '0;
                retry_d = retry_q + 1'b1;
                if (retry_q == RETRY_LAST) state_d = OSC_FAIL;
              end
            end else if (!win_good) begin
              state_d = OSC_FAIL;
            end
          end else begin
            timer_d    = timer_q + 1'b1;
            edge_cnt_d = eval_cnt;
          end
        end
        OSC_FAIL: state_d = OSC_FAIL;
        default:  state_d = OSC_OFF;
      endcase
    end
  end

  // State, counters and registered outputs; flags are decoded from the next state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= OSC_OFF;
      timer_q       <= '0;
      edge_cnt_q    <= '0;
      good_q        <= '0;
      retry_q       <= '0;
      edge_cnt_last <= '0;
      osc_en        <= 1'b0;
      osc_ready     <= 1'b0;
      osc_fail      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      edge_cnt_q    <= edge_cnt_d;
      good_q        <= good_d;
      retry_q       <= retry_d;
      edge_cnt_last <= last_d;
      osc_en        <= (state_d == OSC_STARTUP) || (state_d == OSC_MEASURE) || (state_d == OSC_READY);
      osc_ready     <= (state_d == OSC_READY);
      osc_fail      <= (state_d == OSC_FAIL);
    end
  end

  assign osc_state = state_q;

endmodule

// File: tb/tb_osc_startup_ctrl.sv
// Self-checking bench for osc_startup_ctrl. The oscillator is driven as a
// chosen number of isolated pulses placed mid-window, and a window-level
// reference model predicts the window counts and state progression.
module tb_osc_startup_ctrl;

  localparam int STARTUP = 16;
  localparam int WIN     = 32;
  localparam int MINE    = 6;
  localparam int MAXE    = 10;
  localparam int GOODW   = 2;
  localparam int MAXR    = 3;

  // Spec state codes
  localparam int S_OFF = 0, S_STARTUP = 1, S_MEASURE = 2, S_READY = 3, S_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       osc_req;
  logic       osc_clk_in;
  logic       osc_en;
  logic       osc_ready;
  logic       osc_fail;
  logic [7:0] edge_cnt_last;
  logic [2:0] osc_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rel_e;      // edges since osc_req=1 was first sampled
  int exp_last;   // expected held edge_cnt_last
  int win_mask[$];

  always #5 clk = ~clk;

  osc_startup_ctrl #(
    .STARTUP_CYC (STARTUP),
    .WIN_CYC     (WIN),
    .MIN_EDGES   (MINE),
    .MAX_EDGES   (MAXE),
    .GOOD_WINS   (GOODW),
    .MAX_RETRY   (MAXR),
    .TMR_W       (16),
    .EW          (8)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .osc_req       (osc_req),
    .osc_clk_in    (osc_clk_in),
    .osc_en        (osc_en),
    .osc_ready     (osc_ready),
    .osc_fail      (osc_fail),
    .edge_cnt_last (edge_cnt_last),
    .osc_state     (osc_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at rel_cycle %0d: observed=%0d expected=%0d", tag, rel_e, obs, exp);
    end
  endtask

  // Random choice of k pulse slots out of 12 (slot s -> window offset 4+2s)
  function automatic int make_mask(input int k);
    int m;
    int n;
    int b;
    m = 0;
    n = 0;
    while (n < k) begin
      b = int'($urandom_range(0, 11));
      if (m[b] == 1'b0) begin
        m[b] = 1'b1;
        n++;
      end
    end
    return m;
  endfunction

  task automatic add_win(input int k);
    win_mask.push_back(make_mask(k));
  endtask

  // Oscillator level presented for edge e of the current sequence
  function automatic logic osc_val(input int e);
    int o;
    int j;
    int p;
    int m;
    if (e < STARTUP + 1) return 1'b0;
    o = e - (STARTUP + 1);
    j = o / WIN;
    p = o % WIN;
    if (j >= win_mask.size()) return 1'b0;
    if (p < 4 || p > 26 || (p % 2) != 0) return 1'b0;
    m = win_mask[j];
    return m[(p - 4) / 2];
  endfunction

  // Reference: rising edges of the driven waveform inside window j
  function automatic int rises(input int j);
    int base;
    int n;
    base = STARTUP + 1 + WIN * j;
    n = 0;
    for (int e = base; e < base + WIN; e++)
      if (osc_val(e) && !osc_val(e - 1)) n++;
    return n;
  endfunction

  task automatic tick();
    osc_clk_in = osc_val(rel_e);
    @(posedge clk);
    rel_e++;
    @(negedge clk);
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_state"}, 32'(osc_state), S_OFF);
    chk({tag, "_en"}, 32'(osc_en), 0);
    chk({tag, "_ready"}, 32'(osc_ready), 0);
    chk({tag, "_fail"}, 32'(osc_fail), 0);
    chk({tag, "_last"}, 32'(edge_cnt_last), 32'(exp_last));
  endtask

  // Full sequence from osc_req rise through every queued window (or FAIL)
  task automatic run_windows();
    int mst;
    int good;
    int retry;
    int c;
    int t_end;
    bit ok;
    osc_req = 1'b1;
    rel_e = 0;
    tick();
    chk("startup_en", 32'(osc_en), 1);
    chk("startup_state", 32'(osc_state), S_STARTUP);
    while (rel_e < STARTUP) tick();
    chk("startup_hold", 32'(osc_state), S_STARTUP);
    tick();
    chk("measure_entry", 32'(osc_state), S_MEASURE);
    mst = S_MEASURE;
    good = 0;
    retry = 0;
    for (int j = 0; j < win_mask.size(); j++) begin
      t_end = STARTUP + 1 + WIN * (j + 1);
      while (rel_e < t_end - 1) tick();
      chk("pre_win_state", 32'(osc_state), 32'(mst));
      chk("pre_win_ready", 32'(osc_ready), 32'(mst == S_READY));
      tick();
      c = rises(j);
      ok = (c >= MINE) && (c <= MAXE);
      if (mst == S_MEASURE) begin
        if (ok) begin
          good++;
          if (good == GOODW) mst = S_READY;
        end else begin
          good = 0;
          retry++;
          if (retry == MAXR) mst = S_FAIL;
        end
      end else if (!ok) begin
        mst = S_FAIL;
      end
      exp_last = c;
      chk("win_count", 32'(edge_cnt_last), 32'(c));
      chk("win_state", 32'(osc_state), 32'(mst));
      chk("win_ready", 32'(osc_ready), 32'(mst == S_READY));
      chk("win_fail", 32'(osc_fail), 32'(mst == S_FAIL));
      chk("win_en", 32'(osc_en), 32'(mst != S_FAIL));
      if (mst == S_FAIL) break;
    end
    if (mst == S_FAIL) begin
      repeat (6) tick();
      chk("fail_hold_state", 32'(osc_state), S_FAIL);
      chk("fail_hold_flag", 32'(osc_fail), 1);
      chk("fail_hold_en", 32'(osc_en), 0);
    end
  endtask

  task automatic drop_req();
    osc_req = 1'b0;
    tick();
    chk_off("drop");
  endtask

  task automatic abort_at(input int n, input int exp_state);
    osc_req = 1'b1;
    rel_e = 0;
    repeat (n) tick();
    chk("abort_pre_state", 32'(osc_state), 32'(exp_state));
    osc_req = 1'b0;
    tick();
    chk_off("abort");
  endtask

  initial begin
    int k;
    rst_b = 1'b0;
    osc_req = 1'b0;
    osc_clk_in = 1'b0;
    rel_e = 0;
    exp_last = 0;
    repeat (2) @(negedge clk);
    chk_off("reset");
    rst_b = 1'b1;
    repeat (3) tick();
    chk_off("idle");

    // Nominal start-up, monitoring in READY, then loss of the oscillator
    win_mask.delete();
    add_win(8); add_win(8); add_win(8); add_win(0);
    run_windows();
    drop_req();

    // Dead oscillator
    win_mask.delete();
    add_win(0); add_win(0); add_win(0);
    run_windows();
    drop_req();

    // Range boundaries and retry accounting
    win_mask.delete();
    add_win(6); add_win(10); add_win(6);
    run_windows();
    drop_req();
    win_mask.delete();
    add_win(5); add_win(11); add_win(5);
    run_windows();
    drop_req();
    win_mask.delete();
    add_win(6); add_win(5); add_win(10); add_win(10);
    run_windows();
    drop_req();
    win_mask.delete();
    add_win(5); add_win(6); add_win(11); add_win(6); add_win(5);
    run_windows();
    drop_req();

    // Interrupted sequences followed by a complete restart
    win_mask.delete();
    add_win(8); add_win(8);
    abort_at(8, S_STARTUP);
    run_windows();
    drop_req();
    win_mask.delete();
    add_win(7); add_win(9);
    abort_at(40, S_MEASURE);
    run_windows();
    drop_req();

    // Randomized window counts, biased towards the acceptance boundaries
    for (int t = 0; t < 10; t++) begin
      win_mask.delete();
      for (int j = 0; j < 5; j++) begin
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(5, 11));
        add_win(k);
      end
      run_windows();
      drop_req();
    end

    // Asynchronous reset in the middle of a READY window
    win_mask.delete();
    add_win(8); add_win(8); add_win(8);
    run_windows();
    repeat (10) tick();
    chk("pre_reset_ready", 32'(osc_ready), 1);
    #1 rst_b = 1'b0;
    #1;
    exp_last = 0;
    chk_off("async_reset");
    #1 osc_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) tick();
    chk_off("post_reset");
    osc_req = 1'b1;
    tick();
    chk("post_reset_start", 32'(osc_state), S_STARTUP);
    chk("post_reset_en", 32'(osc_en), 1);
    osc_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
